// File: rtl/array_pkg.sv
// Shared types and default dimensions for the systolic array edge blocks.
package array_pkg;

    localparam int ARRAY_HEIGHT = 8;
    localparam int ARRAY_IWIDTH = 8;

    typedef logic signed [ARRAY_IWIDTH-1:0] ifm_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/array_ifm_feeder_skew_line.sv
// One row of the west-edge skew: a DEPTH-stage {en, clr, data} shift register.
// Define ARRAY_IFM_FEEDER_ZERO_GATE_EN to force data to 0 on disabled stages.
module skew_line #(
    parameter int DEPTH  = 1,
    parameter int IWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_in,
    input  logic                     clr_in,
    input  logic signed [IWIDTH-1:0] data_in,
    output logic                     en_out,
    output logic                     clr_out,
    output logic signed [IWIDTH-1:0] data_out
);

    logic [DEPTH-1:0]         en_q;
    logic [DEPTH-1:0]         clr_q;
    logic signed [IWIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= '0;
            clr_q <= '0;
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
        end else begin
            en_q[0]  <= en_in;
            clr_q[0] <= clr_in;
            for (int k = 1; k < DEPTH; k++) begin
                en_q[k]  <= en_q[k-1];
                clr_q[k] <= clr_q[k-1];
            end
`ifdef ARRAY_IFM_FEEDER_ZERO_GATE_EN
            // Disabled stages carry zero so the multipliers downstream stay quiet.
            data_q[0] <= en_in ? data_in : '0;
            for (int k = 1; k < DEPTH; k++)
                data_q[k] <= en_q[k-1] ? data_q[k-1] : '0;
`else
            if (en_in) data_q[0] <= data_in;
            for (int k = 1; k < DEPTH; k++)
                if (en_q[k-1]) data_q[k] <= data_q[k-1];
`endif
        end
    end

    assign en_out   = en_q[DEPTH-1];
    assign clr_out  = clr_q[DEPTH-1];
    assign data_out = data_q[DEPTH-1];

endmodule

// File: rtl/array_ifm_feeder.sv
// West-edge IFM feeder: accepts HEIGHT-wide vectors and emits them skewed by row.
// Define ARRAY_IFM_FEEDER_ZERO_GATE_EN to zero ifm on rows whose en_i is low.
module array_ifm_feeder
    import array_pkg::*;
#(
    parameter int HEIGHT = ARRAY_HEIGHT,
    parameter int IWIDTH = ARRAY_IWIDTH,
    parameter int MAXLEN = 64,
    parameter int CWIDTH = $clog2(MAXLEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic signed [IWIDTH-1:0] in_data [HEIGHT-1:0],
    output logic [HEIGHT-1:0]        en_i,
    output logic [HEIGHT-1:0]        clr_i,
    output logic signed [IWIDTH-1:0] ifm [HEIGHT-1:0],
    output logic                     busy,
    output logic [CWIDTH-1:0]        vec_cnt,
    output logic                     tile_done
);

    localparam int DW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    feeder_state_e state;
    logic [DW-1:0] drain_cnt;
    logic          accept;
    logic          first_acc;
    logic          end_acc;

    // vec_cnt is 0 in IDLE, so one compare covers both the MAXLEN==1 and saturating cases.
    assign accept    = in_valid && in_ready;
    assign first_acc = accept && (state == IDLE);
    assign end_acc   = accept && (in_last || (vec_cnt == CWIDTH'(MAXLEN - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        vec_cnt <= (state == IDLE) ? CWIDTH'(1) : vec_cnt + CWIDTH'(1);
                        if (end_acc) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= DW'(HEIGHT - 1);
                            tile_done <= 1'(HEIGHT == 1);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    // tile_done is raised one edge early so it coincides with drain_cnt == 0.
                    if (drain_cnt == '0) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        vec_cnt  <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                        if (drain_cnt == DW'(1)) tile_done <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    vec_cnt  <= '0;
                end
            endcase
        end
    end

    for (genvar h = 0; h < HEIGHT; h++) begin : g_row
        skew_line #(
            .DEPTH  (h + 1),
            .IWIDTH (IWIDTH)
        ) u_line (
            .clk      (clk),
            .rst_n    (rst_n),
            .en_in    (accept),
            .clr_in   (first_acc),
            .data_in  (in_data[h]),
            .en_out   (en_i[h]),
            .clr_out  (clr_i[h]),
            .data_out (ifm[h])
        );
    end

endmodule

// File: tb/tb_array_ifm_feeder.sv
// Randomised self-checking bench for array_ifm_feeder against a cycle-scheduled model.
// Honours ARRAY_IFM_FEEDER_ZERO_GATE_EN for the expected value of idle ifm lanes.
module tb_array_ifm_feeder;

    localparam int HEIGHT = 8;
    localparam int IWIDTH = 8;
    localparam int MAXLEN = 4;
    localparam int CWIDTH = $clog2(MAXLEN + 1);
    localparam int RING   = 32;
`ifdef ARRAY_IFM_FEEDER_ZERO_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic in_ready;
    logic signed [IWIDTH-1:0] in_data [HEIGHT-1:0];
    logic [HEIGHT-1:0] en_i;
    logic [HEIGHT-1:0] clr_i;
    logic signed [IWIDTH-1:0] ifm [HEIGHT-1:0];
    logic busy;
    logic [CWIDTH-1:0] vec_cnt;
    logic tile_done;

    array_ifm_feeder #(
        .HEIGHT (HEIGHT),
        .IWIDTH (IWIDTH),
        .MAXLEN (MAXLEN),
        .CWIDTH (CWIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_data   (in_data),
        .en_i      (en_i),
        .clr_i     (clr_i),
        .ifm       (ifm),
        .busy      (busy),
        .vec_cnt   (vec_cnt),
        .tile_done (tile_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: every accept schedules its elements into future cycle slots, one per row.
    logic [HEIGHT-1:0]        ring_en   [RING];
    logic [HEIGHT-1:0]        ring_clr  [RING];
    logic signed [IWIDTH-1:0] ring_data [RING][HEIGHT];
    logic signed [IWIDTH-1:0] m_last    [HEIGHT];
    logic [HEIGHT*IWIDTH-1:0] exp_ifm, act_ifm;
    logic signed [IWIDTH-1:0] e_val;
    int  m_ready_at = 0;
    int  m_done_at  = -1;
    int  m_cnt      = 0;
    bit  m_open     = 1'b0;
    bit  m_busy, m_first;
    int  slot;

    always @(negedge clk) begin
        slot = cyc % RING;
        if (!rst_n) begin
            for (int s = 0; s < RING; s++) begin
                ring_en[s]  = '0;
                ring_clr[s] = '0;
            end
            for (int h = 0; h < HEIGHT; h++) m_last[h] = '0;
            m_ready_at = 0;
            m_done_at  = -1;
            m_cnt      = 0;
            m_open     = 1'b0;
            for (int h = 0; h < HEIGHT; h++) act_ifm[h*IWIDTH +: IWIDTH] = ifm[h];
            checkOutput("rst_in_ready", longint'(in_ready), 1);
            checkOutput("rst_busy", longint'(busy), 0);
            checkOutput("rst_vec_cnt", longint'(vec_cnt), 0);
            checkOutput("rst_tile_done", longint'(tile_done), 0);
            checkOutput("rst_en_clr", longint'({en_i, clr_i}), 0);
            checkOutput("rst_ifm", longint'(act_ifm), 0);
        end else begin
            for (int h = 0; h < HEIGHT; h++) begin
                if (ring_en[slot][h]) begin
                    e_val     = ring_data[slot][h];
                    m_last[h] = e_val;
                end else begin
                    e_val = GATED ? '0 : m_last[h];
                end
                exp_ifm[h*IWIDTH +: IWIDTH] = e_val;
                act_ifm[h*IWIDTH +: IWIDTH] = ifm[h];
            end
            m_busy = m_open || (cyc < m_ready_at);
            checkOutput("in_ready", longint'(in_ready), longint'(cyc >= m_ready_at));
            checkOutput("busy", longint'(busy), longint'(m_busy));
            checkOutput("vec_cnt", longint'(vec_cnt), m_busy ? longint'(m_cnt) : 0);
            checkOutput("tile_done", longint'(tile_done), longint'(cyc == m_done_at));
            checkOutput("en_i", longint'(en_i), longint'(ring_en[slot]));
            checkOutput("clr_i", longint'(clr_i), longint'(ring_clr[slot]));
            checkOutput("ifm", longint'(act_ifm), longint'(exp_ifm));
            ring_en[slot]  = '0;
            ring_clr[slot] = '0;

            if (in_valid && (cyc >= m_ready_at)) begin
                m_first = !m_open;
                m_cnt   = m_first ? 1 : m_cnt + 1;
                m_open  = 1'b1;
                for (int h = 0; h < HEIGHT; h++) begin
                    ring_en[(cyc + 1 + h) % RING][h]   = 1'b1;
                    ring_clr[(cyc + 1 + h) % RING][h]  = m_first;
                    ring_data[(cyc + 1 + h) % RING][h] = in_data[h];
                end
                if (in_last || m_cnt == MAXLEN) begin
                    m_open     = 1'b0;
                    m_ready_at = cyc + HEIGHT + 1;
                    m_done_at  = cyc + HEIGHT;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitNeg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit v, input bit l);
        in_valid = v;
        in_last  = l;
    endtask

    task automatic randomData();
        for (int h = 0; h < HEIGHT; h++) in_data[h] = IWIDTH'($urandom);
    endtask

    task automatic waitReady();
        step();
        for (int k = 0; k < 40 && !in_ready; k++) step();
        if (!in_ready) checkOutput("ready_timeout", 0, 1);
    endtask

    int t;
    int seen;
    logic signed [IWIDTH-1:0] a2, b2;

    initial begin
        for (int h = 0; h < HEIGHT; h++) in_data[h] = '0;
        #1;
        repeat (3) step();
        rst_n = 1'b1;

        // Single-vector tile: values 1..8 walk down the diagonal.
        waitReady();
        for (int h = 0; h < HEIGHT; h++) in_data[h] = IWIDTH'(h + 1);
        t = cyc;
        applyStimulus(1, 1);
        step();
        applyStimulus(0, 0);
        for (int h = 0; h < HEIGHT; h++) begin
            waitNeg(t + 1 + h);
            checkOutput("t1_ifm", longint'(ifm[h]), h + 1);
            checkOutput("t1_en_clr", longint'({en_i[h], clr_i[h]}), 3);
            if (h == 0) checkOutput("t1_ready_lo", longint'(in_ready), 0);
        end
        checkOutput("t1_tile_done", longint'(tile_done), 1);
        waitNeg(t + HEIGHT + 1);
        checkOutput("t1_ready_hi", longint'(in_ready), 1);

        // Four back-to-back vectors, row 0 carrying 10..13.
        waitReady();
        t = cyc;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    randomData();
                    in_data[0] = IWIDTH'(10 + i);
                    applyStimulus(1, i == 3);
                    step();
                end
                applyStimulus(0, 0);
            end
            begin
                waitNeg(t + 1);
                checkOutput("t2_clr0_first", longint'(clr_i[0]), 1);
                checkOutput("t2_ifm0_first", longint'(ifm[0]), 10);
                waitNeg(t + 2);
                checkOutput("t2_clr0_second", longint'(clr_i[0]), 0);
                checkOutput("t2_ifm0_second", longint'(ifm[0]), 11);
                waitNeg(t + 4);
                checkOutput("t2_vec_cnt", longint'(vec_cnt), 4);
                waitNeg(t + 3 + HEIGHT);
                checkOutput("t2_tile_done", longint'(tile_done), 1);
            end
        join

        // Bubble pattern 1,0,1 seen on row 2.
        waitReady();
        t = cyc;
        randomData();
        a2 = in_data[2];
        applyStimulus(1, 0);
        step();
        applyStimulus(0, 0);
        step();
        randomData();
        b2 = in_data[2];
        applyStimulus(1, 1);
        step();
        applyStimulus(0, 0);
        waitNeg(t + 3);
        checkOutput("t3_row2_a", longint'({en_i[2], ifm[2]}), longint'({1'b1, a2}));
        waitNeg(t + 4);
        checkOutput("t3_row2_gap", longint'({en_i[2], ifm[2]}), longint'({1'b0, GATED ? 8'sd0 : a2}));
        waitNeg(t + 5);
        checkOutput("t3_row2_b", longint'({en_i[2], ifm[2]}), longint'({1'b1, b2}));

        // Valid held high with no last: MAXLEN forces the end of tile.
        waitReady();
        t = cyc;
        fork
            begin
                for (int i = 0; i < 13; i++) begin
                    randomData();
                    applyStimulus(1, 0);
                    step();
                end
                applyStimulus(0, 0);
            end
            begin
                waitNeg(t + 4);
                checkOutput("t4_forced_cnt", longint'(vec_cnt), MAXLEN);
                checkOutput("t4_forced_ready", longint'(in_ready), 0);
                waitNeg(t + 3 + HEIGHT);
                checkOutput("t4_tile_done", longint'(tile_done), 1);
                waitNeg(t + 4 + HEIGHT + 1);
                checkOutput("t4_new_clr", longint'({clr_i[0], vec_cnt}), longint'({1'b1, 3'd1}));
            end
        join

        // Reset asserted mid-DRAIN.
        step();
        randomData();
        applyStimulus(1, 1);
        step();
        applyStimulus(0, 0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_outputs", longint'({en_i, clr_i, tile_done, in_ready}), 1);
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (HEIGHT + 6) begin
            @(negedge clk);
            if (en_i != '0 || clr_i != '0 || tile_done) seen++;
        end
        checkOutput("t5_no_stale", seen, 0);

        // Most negative element on every lane.
        waitReady();
        for (int h = 0; h < HEIGHT; h++) in_data[h] = -8'sd128;
        t = cyc;
        applyStimulus(1, 1);
        step();
        applyStimulus(0, 0);
        for (int h = 0; h < HEIGHT; h++) begin
            waitNeg(t + 1 + h);
            checkOutput("t6_neg", longint'(ifm[h]), -128);
        end

        // Random traffic, checked cycle by cycle by the model.
        step();
        for (int i = 0; i < 400; i++) begin
            randomData();
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
            step();
        end
        applyStimulus(0, 0);
        repeat (HEIGHT + 6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/array_ifm_feeder.md
Name: array_ifm_feeder

Overview:
- Transmit side of the systolic array's west-edge input interface.
- Accepts one HEIGHT-wide input-feature-map vector per handshake.
- Produces skewed per-row streams `ifm`/`en_i`/`clr_i`: row h is delayed h cycles relative to row 0, so operands meet weights on the array diagonal.
- Frames tiles: clears accumulators at tile start, drains the skew at tile end, and reports tile completion.

Parameters:
- HEIGHT, 8, number of array rows (output lanes).
- IWIDTH, 8, signed element width.
- MAXLEN, 64, maximum vectors per tile; reaching it forces an end of tile.
- CWIDTH, $clog2(MAXLEN+1), width of the vector counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream vector valid
- in_ready  output  1  feeder can accept a vector
- in_last  input  1  accepted vector is the last of its tile
- in_data  input  signed [IWIDTH-1:0] x [HEIGHT-1:0]  input vector, lane h goes to row h
- en_i  output  [HEIGHT-1:0]  per-row operand enable to the array
- clr_i  output  [HEIGHT-1:0]  per-row accumulator clear, asserted with the first element of a tile
- ifm  output  signed [IWIDTH-1:0] x [HEIGHT-1:0]  per-row operand
- busy  output  1  state != IDLE
- vec_cnt  output  CWIDTH  vectors accepted in the current tile
- tile_done  output  1  one-cycle pulse when the last element leaves row HEIGHT-1

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs are 0 except `in_ready`, which is 1. Delay lines, FSM and counters are cleared. Reset mid-tile abandons the tile silently, with no `tile_done`.
- Accept: an accept occurs on a cycle where `in_valid && in_ready`.
- FSM states:
  - IDLE: `in_ready` = 1. An accept moves to STREAM and marks the vector first-of-tile.
  - STREAM: `in_ready` = 1. An accept with `in_last`, or with `vec_cnt == MAXLEN-1`, moves to DRAIN and loads `drain_cnt` = HEIGHT-1.
  - DRAIN: `in_ready` = 0. `drain_cnt` decrements each cycle. At 0, go to IDLE and assert `tile_done` in that cycle.
- An accept in IDLE with `in_last` = 1 is a single-vector tile and goes directly to DRAIN.
- Skew and latency, for an accept at cycle t:
  - Row h presents `ifm[h]` = `in_data[h]` with `en_i[h]` = 1 at cycle t+1+h (all outputs registered).
  - Row 0 latency is 1 cycle; row HEIGHT-1 latency is HEIGHT cycles.
- `clr_i[h]` = 1 only alongside the first-of-tile element on row h, i.e. with the same skew.
- Bubbles: a cycle with no accept in STREAM injects `en_i` = 0 and `clr_i` = 0 into the stage 0 pipeline. The bubble propagates with the same skew, so relative element order per row is preserved.
- Last element timing: the last accept at t reaches row HEIGHT-1 at t+HEIGHT. DRAIN occupies cycles t+1..t+HEIGHT, so `tile_done` is high at t+HEIGHT. `in_ready` returns to 1 at t+HEIGHT+1, so clears of a new tile never overtake the old tile's elements.
- `vec_cnt`:
  - Increments on each accept.
  - Resets to 1 on a first-of-tile accept.
  - Holds through DRAIN.
  - Cleared to 0 on entering IDLE.
  - Saturates at MAXLEN; the forced last is applied there.
- Element handling: elements pass through unchanged as signed values, with no arithmetic.
- `en_i` = 0 behaviour: `ifm` holds its previous value (see Optional Feature).

Optional Feature:
- Macro: `ARRAY_IFM_FEEDER_ZERO_GATE_EN`.
- Defined: each stage forces `ifm` to 0 whenever its `en_i` is 0. This cuts toggling in the array multipliers.
- Undefined: a stage's data register loads only when its enable is 1 and otherwise holds.
- Control and timing are identical in both builds.

Decomposition:
- Package `array_pkg`:
  - typedef `ifm_t` (signed IWIDTH)
  - FSM enum `feeder_state_e` {IDLE, STREAM, DRAIN}
  - default HEIGHT/IWIDTH constants shared with the array
- Sub-module `skew_line`:
  - Parameters DEPTH, IWIDTH.
  - A DEPTH-stage shift register carrying {en, clr, data}.
  - Instantiated HEIGHT times, with DEPTH = h+1 for row h.
  - Implements the zero-gate macro locally.

Test Plan:
- Reset, then one accept at t=5 with `in_data` = {1..8} and `in_last` = 1 -> `ifm[h]` = h+1 with `en_i[h]` = `clr_i[h]` = 1 at cycle 6+h; `tile_done` at cycle 13; `in_ready` = 0 on cycles 6..13.
- 4 back-to-back vectors (row 0 values 10, 11, 12, 13), last on the 4th -> `clr_i[0]` only with 10, `vec_cnt` = 4, `tile_done` 8 cycles after the 4th accept.
- `in_valid` pattern 1,0,1 in STREAM -> every row shows en pattern 1,0,1 offset by h, with values unchanged. With the macro defined, `ifm` = 0 in the gap.
- MAXLEN=4, `in_valid` held high, `in_last` never -> forced DRAIN after the 4th accept; `tile_done` fires; the 5th vector is accepted after DRAIN with `clr_i` set.
- Deassert `rst_n` during DRAIN -> all `en_i`/`clr_i`/`tile_done` go 0 immediately; `in_ready` = 1; no stale elements appear after release.
- Max-negative element -128 on all lanes -> `ifm` = -128 (sign preserved) on every row.
